// File: rtl/seg7_scan_driver_if.sv
// ============================================================================
//  Module      : seg7_scan_driver_if
//  Description : BCD digit-pair input strobe and multiplexed display outputs.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface seg7_scan_driver_if;
   logic       in_valid;
   logic [3:0] tens_i;
   logic [3:0] ones_i;
   logic [6:0] seg_o;
   logic [1:0] an_o;
   logic       frame_tick;
   logic       upd_ack;

   modport master (
      output in_valid, tens_i, ones_i,
      input  seg_o, an_o, frame_tick, upd_ack
   );

   modport slave (
      input  in_valid, tens_i, ones_i,
      output seg_o, an_o, frame_tick, upd_ack
   );
endinterface

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : 2-digit multiplexed 7-segment scan driver with tear-free
//                frame-boundary updates, blank guard and leading-zero blanking.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
   parameter int REFRESH_DIV    = 50000,
   parameter int GUARD          = 4,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1,
   parameter int BLANK_LEAD0    = 1
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   seg7_scan_driver_if.slave bus
);

   localparam int              CNT_W      = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] c_guard    = CNT_W'(GUARD);
   localparam logic [6:0]       c_seg_off  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [1:0]       c_an_off   = (AN_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

   typedef enum logic {ONES = 1'b0, TENS = 1'b1} slot_t;

   slot_t            r_slot;
   logic [CNT_W-1:0] r_div_cnt;
   logic [3:0]       r_disp_t, r_disp_o;
   logic [3:0]       r_pend_t, r_pend_o;
   logic             r_pend_vld;
   logic [6:0]       r_seg;
   logic [1:0]       r_an;
   logic             r_frame_tick, r_upd_ack;

   logic             w_boundary;
   logic [1:0]       w_an_act, w_an_nxt;
   logic [6:0]       w_seg_act, w_seg_nxt;
   logic [3:0]       w_digit;

   function automatic logic [6:0] f_seg_code(input logic [3:0] d);
      case (d)
         4'd0:    f_seg_code = 7'h3F;
         4'd1:    f_seg_code = 7'h06;
         4'd2:    f_seg_code = 7'h5B;
         4'd3:    f_seg_code = 7'h4F;
         4'd4:    f_seg_code = 7'h66;
         4'd5:    f_seg_code = 7'h6D;
         4'd6:    f_seg_code = 7'h7D;
         4'd7:    f_seg_code = 7'h07;
         4'd8:    f_seg_code = 7'h7F;
         4'd9:    f_seg_code = 7'h6F;
         default: f_seg_code = 7'h40;
      endcase
   endfunction

   assign w_boundary = (r_slot == TENS) && (r_div_cnt == c_cnt_last);

   // Active-high anode pick: bit0 = ones, bit1 = tens; at most one bit ever set.
   always_comb begin
      w_an_act = 2'b00;
      w_digit  = r_disp_o;
      if (r_div_cnt >= c_guard) begin
         if (r_slot == ONES) begin
            w_an_act = 2'b01;
         end else if (!((BLANK_LEAD0 != 0) && (r_disp_t == 4'd0))) begin
            w_an_act = 2'b10;
            w_digit  = r_disp_t;
         end
      end
      w_seg_act = (w_an_act == 2'b00) ? 7'h00 : f_seg_code(w_digit);
   end

   if (SEG_ACTIVE_LOW != 0) begin : g_seg_low
      assign w_seg_nxt = ~w_seg_act;
   end else begin : g_seg_high
      assign w_seg_nxt = w_seg_act;
   end

   if (AN_ACTIVE_LOW != 0) begin : g_an_low
      assign w_an_nxt = ~w_an_act;
   end else begin : g_an_high
      assign w_an_nxt = w_an_act;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_slot       <= ONES;
         r_div_cnt    <= '0;
         r_disp_t     <= 4'd0;
         r_disp_o     <= 4'd0;
         r_pend_t     <= 4'd0;
         r_pend_o     <= 4'd0;
         r_pend_vld   <= 1'b0;
         r_seg        <= c_seg_off;
         r_an         <= c_an_off;
         r_frame_tick <= 1'b0;
         r_upd_ack    <= 1'b0;
      end else begin
         if (r_div_cnt == c_cnt_last) begin
            r_div_cnt <= '0;
            r_slot    <= (r_slot == ONES) ? TENS : ONES;
         end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
         end

         r_frame_tick <= w_boundary;
         r_upd_ack    <= 1'b0;

         // A strobe landing on the boundary itself bypasses the pending slot.
         if (w_boundary && bus.in_valid) begin
            r_disp_t   <= bus.tens_i;
            r_disp_o   <= bus.ones_i;
            r_pend_vld <= 1'b0;
            r_upd_ack  <= 1'b1;
         end else if (w_boundary && r_pend_vld) begin
            r_disp_t   <= r_pend_t;
            r_disp_o   <= r_pend_o;
            r_pend_vld <= 1'b0;
            r_upd_ack  <= 1'b1;
         end else if (bus.in_valid) begin
            r_pend_t   <= bus.tens_i;
            r_pend_o   <= bus.ones_i;
            r_pend_vld <= 1'b1;
         end

         r_seg <= w_seg_nxt;
         r_an  <= w_an_nxt;
      end
   end

   assign bus.seg_o      = r_seg;
   assign bus.an_o       = r_an;
   assign bus.frame_tick = r_frame_tick;
   assign bus.upd_ack    = r_upd_ack;

endmodule

`default_nettype wire
